output_writeback: RTL and testbench

Drains results from the bottom edge of the systolic array back into output memory: the write-side counterpart of the weight/data read path that feeds the array. Each column's results emerge skewed by one cycle per column index; the block deskews them into full rows, narrows each accumulator to an 8-bit element, and writes one row per cycle into a `memArr`-style write port at incrementing addresses from a base. The block sits between the array's output edge and the output `memArr`, under the top-level control's start/done handshake.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/skew_delay.sv | 51 +++++
 rtl/output_writeback.sv | 170 +++++++++++++++++
 tb/tb_output_writeback.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: writeback FSM states, element width and the
// signed saturation helper used when OUT_SATURATE_EN is defined.
package tpu_pkg;

  localparam int ELEM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } wb_state_e;

  // Clamp a sign-extended accumulator into the signed 8-bit element range.
  function automatic logic [ELEM_WIDTH-1:0] saturate_elem(input logic signed [31:0] acc);
    if (acc > 32'sd127) begin
      return 8'h7f;
    end else if (acc < -32'sd128) begin
      return 8'h80;
    end else begin
      return acc[ELEM_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-depth delay line carrying a valid bit and its data word together;
// a depth of zero is a plain wire. Clears on the active-low async reset.
module skew_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_line
      logic [DEPTH-1:0]            valid_q, valid_d;
      logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

      always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/output_writeback.sv
// Deskews the systolic array's bottom-edge results into rows, narrows each
// column to 8 bits and writes one row per cycle at incrementing addresses.
// Define OUT_SATURATE_EN to clamp instead of wrapping when narrowing.
module output_writeback
  import tpu_pkg::*;
#(
  parameter int width_height = 16,
  parameter int acc_width    = 16,
  parameter int addr_width   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [addr_width-1:0]                base_addr,
  input  logic [addr_width-1:0]                row_count,
  input  logic [width_height-1:0]              arr_valid,
  input  logic [width_height*acc_width-1:0]    arr_data,
  output logic                                 mem_wr_en,
  output logic [addr_width-1:0]                mem_wr_addr,
  output logic [width_height*ELEM_WIDTH-1:0]   mem_wr_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  wb_state_e                                 state_q, state_d;
  logic [addr_width-1:0]                     addr_cnt_q, addr_cnt_d;
  logic [addr_width-1:0]                     remain_q, remain_d;
  logic                                      last_wr_q, last_wr_d;
  logic                                      err_q, err_d;
  logic                                      mem_wr_en_q, mem_wr_en_d;
  logic [addr_width-1:0]                     mem_wr_addr_q, mem_wr_addr_d;
  logic [width_height*ELEM_WIDTH-1:0]        mem_wr_data_q, mem_wr_data_d;

  logic                                      accept_start;
  logic                                      in_window;
  logic                                      stray_valid;
  logic                                      lane_mismatch;
  logic [width_height-1:0]                   gated_valid;
  logic [width_height-1:0]                   dsk_valid;
  logic [width_height-1:0][acc_width-1:0]    dsk_data;
  logic [width_height-1:0][ELEM_WIDTH-1:0]   row_narrow;

  // Valids are only admitted into the delay lines while a job is running
  // (or starting this cycle); anything else is dropped and flagged.
  assign accept_start  = (state_q == IDLE) && start;
  assign in_window     = (state_q == COLLECT) || (accept_start && (row_count != '0));
  assign gated_valid   = arr_valid & {width_height{in_window}};
  assign stray_valid   = (|arr_valid) && !in_window;
  assign lane_mismatch = |(dsk_valid ^ {width_height{dsk_valid[0]}});

  genvar c;
  generate
    for (c = 0; c < width_height; c++) begin : g_col
      skew_delay #(
        .DEPTH(width_height - 1 - c),
        .WIDTH(acc_width)
      ) u_skew (
        .clk      (clk),
        .reset    (reset),
        .in_valid (gated_valid[c]),
        .in_data  (arr_data[c*acc_width +: acc_width]),
        .out_valid(dsk_valid[c]),
        .out_data (dsk_data[c])
      );
    end
  endgenerate

`ifdef OUT_SATURATE_EN
  always_comb begin
    row_narrow = '0;
    for (int i = 0; i < width_height; i++) begin
      row_narrow[i] = saturate_elem(32'(signed'(dsk_data[i])));
    end
  end
`else
  logic unused_high_bits;
  assign unused_high_bits = ^dsk_data;

  always_comb begin
    row_narrow = '0;
    for (int i = 0; i < width_height; i++) begin
      row_narrow[i] = dsk_data[i][ELEM_WIDTH-1:0];
    end
  end
`endif

  // The final write raises last_wr; DONE is entered the cycle after that
  // write is visible so done/busy line up with the registered strobe.
  always_comb begin
    state_d       = state_q;
    addr_cnt_d    = addr_cnt_q;
    remain_d      = remain_q;
    last_wr_d     = 1'b0;
    err_d         = err_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    if (stray_valid) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = stray_valid;
          if (row_count == '0) begin
            state_d = DONE;
          end else begin
            state_d    = COLLECT;
            addr_cnt_d = base_addr;
            remain_d   = row_count;
          end
        end
      end
      COLLECT: begin
        if (lane_mismatch) begin
          err_d = 1'b1;
        end
        if (last_wr_q) begin
          state_d = DONE;
        end else if (dsk_valid[0] && (remain_q != '0)) begin
          mem_wr_en_d   = 1'b1;
          mem_wr_addr_d = addr_cnt_q;
          mem_wr_data_d = row_narrow;
          addr_cnt_d    = addr_cnt_q + 1'b1;
          remain_d      = remain_q - 1'b1;
          last_wr_d     = (remain_q == addr_width'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_cnt_q    <= '0;
      remain_q      <= '0;
      last_wr_q     <= 1'b0;
      err_q         <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      remain_q      <= remain_d;
      last_wr_q     <= last_wr_d;
      err_q         <= err_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = (state_q == COLLECT);
  assign done        = (state_q == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback (4x4 array): skewed row feeds,
// expected writes computed from row/cycle arithmetic, directed and random jobs.
module tb_output_writeback;

  localparam int WH = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        base_addr = '0;
  logic [7:0]        row_count = '0;
  logic [WH-1:0]     arr_valid = '0;
  logic [WH*AW-1:0]  arr_data = '0;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_addr;
  logic [WH*DW-1:0]  mem_wr_data;
  logic              busy;
  logic              done;
  logic              err;

  output_writeback #(
    .width_height(WH),
    .acc_width   (AW),
    .addr_width  (8)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .arr_valid  (arr_valid),
    .arr_data   (arr_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] row_val [16][WH];

  int          obs_cyc[$];
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          done_cyc[$];
  bit          busy_seen;
  int          busy_first;
  bit          busy_with_done;

  int          exp_cyc[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_dchk[$];
  int          job_start;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(mem_wr_addr);
      obs_data.push_back(mem_wr_data);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      if (busy) busy_with_done = 1'b1;
    end
    if (busy && !busy_seen) begin
      busy_seen  = 1'b1;
      busy_first = cyc;
    end
  end

  function automatic logic [7:0] model_narrow(input logic [15:0] a);
    int v;
    v = $signed(a);
`ifdef OUT_SATURATE_EN
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
`endif
    return a[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearRecords();
    obs_cyc.delete();
    obs_addr.delete();
    obs_data.delete();
    done_cyc.delete();
    exp_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_dchk.delete();
    busy_seen      = 1'b0;
    busy_first     = -1;
    busy_with_done = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    checkOutput({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'd0);
    checkOutput({tag, "_wr_data"}, 64'(mem_wr_data), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Pulse start, then feed n_feed rows skewed one cycle per column index.
  // Row r of column c goes out at cycle t0+r+c and is written at t0+r+WH.
  task automatic applyStimulus(input logic [7:0] base, input logic [7:0] n, input int n_feed,
                               input int drop_row, input int drop_col, input int rst_k);
    int          t0;
    logic [7:0]  a;
    logic [31:0] d;
    clearRecords();
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    row_count = n;
    job_start = cyc;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int r = 0; r < n_feed && r < int'(n); r++) begin
      if (rst_k < 0 || r + WH <= rst_k) begin
        a = base + 8'(r);
        for (int c = 0; c < WH; c++) d[c*8 +: 8] = model_narrow(row_val[r][c]);
        exp_cyc.push_back(t0 + r + WH);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_dchk.push_back(r != drop_row);
      end
    end
    for (int k = 0; k < n_feed + WH - 1; k++) begin
      if (k == rst_k) begin
        #1 rst_n = 1'b0;
        arr_valid = '0;
        arr_data = '0;
        #1 checkAllZero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int c = 0; c < WH; c++) begin
        int r;
        r = k - c;
        arr_valid[c] = 1'b0;
        arr_data[c*AW +: AW] = '0;
        if (r >= 0 && r < n_feed) begin
          arr_valid[c] = !(r == drop_row && c == drop_col);
          arr_data[c*AW +: AW] = row_val[r][c];
        end
      end
      @(negedge clk);
    end
    arr_valid = '0;
    arr_data = '0;
  endtask

  task automatic checkWrites(input string tag, input bit expect_done, input bit exp_err, input int n);
    int budget;
    int m;
    budget = 0;
    if (expect_done) begin
      while (done_cyc.size() == 0 && budget < 80) begin
        @(negedge clk);
        budget++;
      end
      checkOutput({tag, "_done_seen"}, 64'(done_cyc.size() != 0), 64'd1);
    end else begin
      repeat (20) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_nwr"}, 64'(obs_cyc.size()), 64'(exp_cyc.size()));
    m = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < m; i++) begin
      checkOutput({tag, "_cyc"}, 64'(obs_cyc[i]), 64'(exp_cyc[i]));
      checkOutput({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      if (exp_dchk[i]) checkOutput({tag, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
    end
    if (expect_done && done_cyc.size() != 0) begin
      checkOutput({tag, "_ndone"}, 64'(done_cyc.size()), 64'd1);
      if (n == 0) begin
        checkOutput({tag, "_done_cyc"}, 64'(done_cyc[0]), 64'(job_start + 1));
        checkOutput({tag, "_busy_seen"}, 64'(busy_seen), 64'd0);
      end else begin
        checkOutput({tag, "_done_cyc"}, 64'(done_cyc[0]), 64'(exp_cyc[exp_cyc.size()-1] + 1));
        checkOutput({tag, "_busy_first"}, 64'(busy_first), 64'(job_start + 1));
        checkOutput({tag, "_busy_at_done"}, 64'(busy_with_done), 64'd0);
      end
    end
    checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done_end"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic randomRows(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < WH; c++)
        row_val[r][c] = 16'($urandom);
  endtask

  initial begin
    int n;
    clearRecords();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] job A: base 0x10, 3 rows of r*4+c");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < WH; c++)
        row_val[r][c] = 16'(r * 4 + c);
    applyStimulus(8'h10, 8'd3, 3, -1, -1, -1);
    checkWrites("jobA", 1'b1, 1'b0, 3);

    $display("[TB] job B: address wrap from 0xFE, narrowing extremes");
    randomRows(3);
    row_val[0][0] = 16'h0190;
    row_val[0][1] = 16'hff00;
    row_val[1][2] = 16'h007f;
    row_val[2][3] = 16'hff80;
    applyStimulus(8'hfe, 8'd3, 3, -1, -1, -1);
    checkWrites("jobB", 1'b1, 1'b0, 3);

    $display("[TB] job C: zero row count");
    applyStimulus(8'h40, 8'd0, 0, -1, -1, -1);
    checkWrites("jobC", 1'b1, 1'b0, 0);

    $display("[TB] job D: column 2 valid dropped on row 1");
    randomRows(5);
    applyStimulus(8'h20, 8'd5, 5, 1, 2, -1);
    checkWrites("jobD", 1'b1, 1'b1, 5);
    repeat (5) @(negedge clk);
    checkOutput("err_sticky", 64'(err), 64'd1);

    $display("[TB] job E: next start clears err");
    randomRows(4);
    applyStimulus(8'($urandom), 8'd4, 4, -1, -1, -1);
    checkWrites("jobE", 1'b1, 1'b0, 4);

    $display("[TB] stray valid while idle");
    clearRecords();
    @(negedge clk);
    arr_valid = 4'b0100;
    arr_data = 64'($urandom);
    @(negedge clk);
    arr_valid = '0;
    arr_data = '0;
    repeat (8) @(negedge clk);
    checkOutput("stray_err", 64'(err), 64'd1);
    checkOutput("stray_nwr", 64'(obs_cyc.size()), 64'd0);

    $display("[TB] job F: reset during row 1 of 3");
    randomRows(3);
    applyStimulus(8'h30, 8'd3, 3, -1, -1, 4);
    checkWrites("jobF", 1'b0, 1'b0, 3);

    $display("[TB] job G: clean run after reset");
    randomRows(6);
    applyStimulus(8'h80, 8'd6, 6, -1, -1, -1);
    checkWrites("jobG", 1'b1, 1'b0, 6);

    for (int j = 0; j < 3; j++) begin
      n = $urandom_range(1, 8);
      randomRows(n);
      $display("[TB] random job %0d: %0d rows", j, n);
      applyStimulus(8'($urandom), 8'(n), n, -1, -1, -1);
      checkWrites("jobR", 1'b1, 1'b0, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
